// File: rtl/minirv_pkg.sv
// Shared miniRV fetch-stage definitions: default widths/vectors and the
// next-PC source and PC generator FSM state encodings.
package minirv_pkg;

  localparam int unsigned DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_HOLD,
    NPC_BR,
    NPC_JALR,
    NPC_TRAP
  } npc_sel_e;

  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Redirect/control inputs and fetch outputs of the PC generator.
interface pc_gen_if
  import minirv_pkg::*;
#(
  parameter int unsigned XLEN = DEF_XLEN
);

  logic            stall;
  logic            br_take;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] br_imm;
  logic            jalr_take;
  logic [XLEN-1:0] jalr_base;
  logic [XLEN-1:0] jalr_imm;
  logic            trap;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_valid;
  logic            flush;
  logic            misalign;

  modport master (
    output stall, br_take, br_pc, br_imm, jalr_take, jalr_base, jalr_imm, trap,
    input  pc, pc_plus4, fetch_valid, flush, misalign
  );

  modport slave (
    input  stall, br_take, br_pc, br_imm, jalr_take, jalr_base, jalr_imm, trap,
    output pc, pc_plus4, fetch_valid, flush, misalign
  );

endinterface

// File: rtl/pc_gen_npc_mux.sv
// Combinational next-PC select: fixed-priority source choice, target adders
// and misaligned-target redirection to the trap vector.
module npc_mux
  import minirv_pkg::*;
#(
  parameter int unsigned     XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC)
) (
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            br_take,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic            jalr_take,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic            trap,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] npc,
  output npc_sel_e        sel,
  output logic            misalign
);

  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_tgt;

  assign pc_plus4 = pc + XLEN'(4);
  assign br_tgt   = br_pc + br_imm;
  assign jalr_tgt = (jalr_base + jalr_imm) & ~XLEN'(1);

  always_comb begin
    sel      = NPC_SEQ;
    npc      = pc_plus4;
    misalign = 1'b0;
    if (trap) begin
      sel = NPC_TRAP;
      npc = TRAP_VEC;
    end else if (jalr_take) begin
      sel = NPC_JALR;
      // bit 0 is already cleared, so only bit 1 can make the target misaligned
      if (jalr_tgt[1]) begin
        misalign = 1'b1;
        npc      = TRAP_VEC;
      end else begin
        npc = jalr_tgt;
      end
    end else if (br_take) begin
      sel = NPC_BR;
      if (br_tgt[1:0] != 2'b00) begin
        misalign = 1'b1;
        npc      = TRAP_VEC;
      end else begin
        npc = br_tgt;
      end
    end else if (stall) begin
      sel = NPC_HOLD;
      npc = pc;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// miniRV fetch PC generator: post-reset hold window FSM and PC register,
// with next-PC selection delegated to npc_mux.
module pc_gen
  import minirv_pkg::*;
#(
  parameter int unsigned     XLEN        = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DEF_TRAP_VEC),
  parameter int unsigned     HOLD_CYCLES = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.slave  bus
);

  pc_state_e       state_q, state_d;
  logic [3:0]      hold_cnt_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] pc_plus4;
  npc_sel_e        sel;
  logic            mux_misalign;
  logic            run;

  npc_mux #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_npc_mux (
    .pc        (pc_q),
    .stall     (bus.stall),
    .br_take   (bus.br_take),
    .br_pc     (bus.br_pc),
    .br_imm    (bus.br_imm),
    .jalr_take (bus.jalr_take),
    .jalr_base (bus.jalr_base),
    .jalr_imm  (bus.jalr_imm),
    .trap      (bus.trap),
    .pc_plus4  (pc_plus4),
    .npc       (npc),
    .sel       (sel),
    .misalign  (mux_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      pc_q       <= RESET_VEC;
    end else begin
      state_q <= state_d;
      if (state_q == ST_HOLD) begin
        hold_cnt_q <= hold_cnt_q + 4'd1;
      end
      if (state_q == ST_RUN) begin
        pc_q <= npc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: if (hold_cnt_q == 4'(HOLD_CYCLES)) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_HOLD;
    endcase
  end

  assign run             = (state_q == ST_RUN);
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = run;
  assign bus.flush       = run && (sel inside {NPC_TRAP, NPC_JALR, NPC_BR});
  assign bus.misalign    = run && mux_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized redirects
// compared against a cycle-level reference of the fetch PC behaviour.
module tb_pc_gen;

  localparam int unsigned H       = 2;
  localparam logic [31:0] RST_VEC = 32'h0000_0000;
  localparam logic [31:0] TRP_VEC = 32'h0000_0100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  logic [31:0] m_pc    = RST_VEC;
  int unsigned m_edges = 0;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN        (32),
    .RESET_VEC   (RST_VEC),
    .TRAP_VEC    (TRP_VEC),
    .HOLD_CYCLES (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Fetch is live once more than H edges have passed since reset release.
  function automatic logic model_run();
    return m_edges > H;
  endfunction

  function automatic void model_next(output logic [31:0] npc, output logic fl,
                                     output logic ms);
    logic [31:0] t;
    npc = m_pc;
    fl  = 1'b0;
    ms  = 1'b0;
    if (model_run()) begin
      if (bus.trap) begin
        fl = 1'b1; npc = TRP_VEC;
      end else if (bus.jalr_take) begin
        t  = (bus.jalr_base + bus.jalr_imm) & 32'hFFFF_FFFE;
        fl = 1'b1; ms = (t % 4) != 0; npc = ms ? TRP_VEC : t;
      end else if (bus.br_take) begin
        t  = bus.br_pc + bus.br_imm;
        fl = 1'b1; ms = (t % 4) != 0; npc = ms ? TRP_VEC : t;
      end else if (!bus.stall) begin
        npc = m_pc + 32'd4;
      end
    end
  endfunction

  task automatic drive(input logic st, input logic bt, input logic [31:0] bpc,
                       input logic [31:0] bimm, input logic jt, input logic [31:0] jb,
                       input logic [31:0] ji, input logic tr);
    bus.stall = st; bus.br_take = bt; bus.br_pc = bpc; bus.br_imm = bimm;
    bus.jalr_take = jt; bus.jalr_base = jb; bus.jalr_imm = ji; bus.trap = tr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic tick();
    logic [31:0] npc;
    logic fl, ms;
    model_next(npc, fl, ms);
    @(posedge clk);
    #1;
    if (model_run()) m_pc = npc;
    if (m_edges < 1000) m_edges++;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 32'h10, 32'h20, 1'b1, 32'h44, 32'h0, 1'b1);
    @(posedge clk); #1;
    tests_run++;
    if (bus.pc !== RST_VEC || bus.fetch_valid !== 1'b0 || bus.flush !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: pc=%h fv=%b flush=%b, want pc=%h fv=0 flush=0",
               bus.pc, bus.fetch_valid, bus.flush, RST_VEC);
    end
    rst_n = 1'b1; m_pc = RST_VEC; m_edges = 0;
    for (int i = 0; i < int'(H); i++) begin
      tests_run++;
      if (bus.flush !== 1'b0 || bus.misalign !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_flush[%0d]: flush=%b misalign=%b, want 0/0", i, bus.flush, bus.misalign);
      end
      tick();
      tests_run++;
      if (bus.pc !== RST_VEC || bus.fetch_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_window[%0d]: pc=%h fv=%b, want %h/0", i, bus.pc, bus.fetch_valid, RST_VEC);
      end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (bus.pc !== 32'(4 * i) || bus.fetch_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL first_fetch[%0d]: pc=%h fv=%b, want %h/1", i, bus.pc, bus.fetch_valid, 4 * i);
      end
    end
  endtask

  task automatic test_branch();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h40, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h3C, 32'h20, 1'b0, '0, '0, 1'b0);
    tests_run++;
    if (bus.pc !== 32'h40 || bus.flush !== 1'b1 || bus.misalign !== 1'b0) begin
      tests_failed++;
      $display("FAIL branch_flush: pc=%h flush=%b misalign=%b, want 40/1/0", bus.pc, bus.flush, bus.misalign);
    end
    tick();
    tests_run++;
    if (bus.pc !== 32'h5C) begin
      tests_failed++;
      $display("FAIL branch_target: pc=%h, want 0000005c", bus.pc);
    end
  endtask

  task automatic test_jalr();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h101, 32'h3, 1'b0);
    tests_run++;
    if (bus.flush !== 1'b1 || bus.misalign !== 1'b0) begin
      tests_failed++;
      $display("FAIL jalr_aligned_flags: flush=%b misalign=%b, want 1/0", bus.flush, bus.misalign);
    end
    tick();
    tests_run++;
    if (bus.pc !== 32'h104) begin
      tests_failed++;
      $display("FAIL jalr_aligned_pc: pc=%h, want 00000104", bus.pc);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h102, 32'h0, 1'b0);
    tests_run++;
    if (bus.flush !== 1'b1 || bus.misalign !== 1'b1) begin
      tests_failed++;
      $display("FAIL jalr_misalign_flags: flush=%b misalign=%b, want 1/1", bus.flush, bus.misalign);
    end
    tick();
    tests_run++;
    if (bus.pc !== TRP_VEC) begin
      tests_failed++;
      $display("FAIL jalr_misalign_pc: pc=%h, want %h", bus.pc, TRP_VEC);
    end
  endtask

  task automatic test_stall();
    logic [31:0] want_pc[3] = '{32'h80, 32'h200, 32'h200};
    logic        want_fl[3] = '{1'b0, 1'b1, 1'b0};
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h80, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) drive(1'b1, 1'b1, 32'h1F0, 32'h10, 1'b0, '0, '0, 1'b0);
      else        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      tests_run++;
      if (bus.pc !== 32'h80 + ((i == 2) ? 32'h180 : 32'h0) || bus.flush !== want_fl[i] ||
          bus.fetch_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_cycle[%0d]: pc=%h flush=%b fv=%b, want flush=%b fv=1",
                 i, bus.pc, bus.flush, bus.fetch_valid, want_fl[i]);
      end
      tick();
      tests_run++;
      if (bus.pc !== want_pc[i]) begin
        tests_failed++;
        $display("FAIL stall_pc[%0d]: pc=%h, want %h", i, bus.pc, want_pc[i]);
      end
    end
  endtask

  task automatic test_priority_wrap();
    drive(1'b1, 1'b1, 32'h3, 32'h0, 1'b1, 32'h6, 32'h0, 1'b1);
    tests_run++;
    if (bus.flush !== 1'b1 || bus.misalign !== 1'b0) begin
      tests_failed++;
      $display("FAIL trap_priority_flags: flush=%b misalign=%b, want 1/0", bus.flush, bus.misalign);
    end
    tick();
    tests_run++;
    if (bus.pc !== TRP_VEC) begin
      tests_failed++;
      $display("FAIL trap_priority_pc: pc=%h, want %h", bus.pc, TRP_VEC);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'hFFFF_FFF0, 32'hC, 1'b0);
    tick();
    idle();
    tests_run++;
    if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_plus4: pc=%h pc_plus4=%h, want fffffffc/00000000", bus.pc, bus.pc_plus4);
    end
    tick();
    tests_run++;
    if (bus.pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_pc: pc=%h, want 00000000", bus.pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] npc;
    logic fl, ms;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC),
            $urandom_range(0, 5) == 0, $urandom(),
            ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom(), $urandom_range(0, 15) == 0);
      model_next(npc, fl, ms);
      tests_run++;
      if (bus.flush !== fl || bus.misalign !== ms || bus.pc_plus4 !== m_pc + 32'd4) begin
        tests_failed++;
        $display("FAIL rand_comb[%0d]: flush=%b misalign=%b plus4=%h, want %b/%b/%h",
                 i, bus.flush, bus.misalign, bus.pc_plus4, fl, ms, m_pc + 32'd4);
      end
      tick();
      tests_run++;
      if (bus.pc !== m_pc || bus.fetch_valid !== model_run()) begin
        tests_failed++;
        $display("FAIL rand_pc[%0d]: pc=%h fv=%b, want %h/%b", i, bus.pc, bus.fetch_valid, m_pc, model_run());
      end
    end
  endtask

  task automatic test_midrun_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 32'h1234, 32'h0, 1'b0);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    m_pc = RST_VEC; m_edges = 0;
    tests_run++;
    if (bus.pc !== RST_VEC || bus.fetch_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: pc=%h fv=%b, want %h/0", bus.pc, bus.fetch_valid, RST_VEC);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < int'(H) + 2; i++) begin
      if (i == int'(H)) idle();
      tick();
      tests_run++;
      if (bus.fetch_valid !== (i >= int'(H)) || bus.pc !== ((i > int'(H)) ? 32'h4 : RST_VEC)) begin
        tests_failed++;
        $display("FAIL rehold[%0d]: pc=%h fv=%b, want fv=%b", i, bus.pc, bus.fetch_valid, i >= int'(H));
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_stall();
    test_priority_wrap();
    test_random();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
